m_mmio_resp: RTL and testbench
==============================

Name: m_mmio_resp

Overview:
- Memory-mapped I/O responder on the data-memory side of the m_proc11 load/store interface.
- Presents the same port contract as m_memory: word address, write enable, write data, and registered read data one cycle later.
- It is selected by an upper-address decode in the top level, and its read data is muxed into the load path in place of m_dmem.
- It holds the LED and 7-segment display registers, a free-running cycle counter with a compare flag, and debounced button status with press-edge flags.

Parameters:
- DEBOUNCE, 16, number of consecutive stable cycles a synchronized button must hold before its debounced level changes (minimum 1).
- LED_W, 16, width of the LED register.

Ports:
- w_clk  in  1  system clock, the only clock.
- w_rst  in  1  reset; synchronous, active-high.
- w_sel  in  1  block selected for this access.
- w_addr  in  4  word offset within the block.
- w_we  in  1  write strobe; effective only when w_sel=1.
- w_din  in  32  write data.
- r_dout  out  32  read data, registered.
- w_btnu  in  1  raw asynchronous button input.
- w_btnd  in  1  raw asynchronous button input.
- r_led  out  LED_W  LED register value.
- r_seg  out  32  value driven to m_7segcon w_din.
- r_irq  out  1  OR of all sticky flags (compare match, edge flags).

Behaviour:
- Register map (w_addr):
  - 0 LED: RW, lower LED_W bits; upper bits read as 0.
  - 1 SEG: RW, 32 bits.
  - 2 CNT: RW, 32-bit counter.
  - 3 CMP: RW, 32-bit compare value.
  - 4 BTN: RO; bit0 = debounced btnu, bit1 = debounced btnd.
  - 5 FLAG: write-1-to-clear; bit0 = compare match, bit1 = btnu press, bit2 = btnd press.
  - 6..15: read 0, writes ignored.
- Read timing:
  - On each posedge with w_sel=1, r_dout <= current register value at w_addr.
  - With w_sel=0, r_dout holds its previous value.
  - Latency is 1 cycle.
  - Read and write to the same address in the same cycle returns the OLD value, matching m_memory.
- Writes take effect at the posedge where w_sel=1 and w_we=1.
- Counter:
  - CNT increments by 1 every cycle and wraps 0xFFFFFFFF -> 0.
  - A CPU write loads w_din; the write wins over the increment, and counting resumes from the written value the next cycle.
- Compare:
  - When the pre-increment CNT equals CMP, FLAG[0] sets on that edge.
  - Set beats clear in the same cycle.
- Button path:
  - Each button passes a 2-flop synchronizer, then a debounce counter.
  - The counter resets whenever the synchronized value differs from the debounced level.
  - When the counter reaches DEBOUNCE-1 with the value still differing, the debounced level takes the new value.
  - A 0->1 debounced transition sets the corresponding FLAG bit.
  - Set beats a same-cycle W1C.
- r_irq is a register, equal to |FLAG, updated one cycle after any FLAG change.
- Reset (w_rst=1 at a posedge) forces the following to 0, regardless of w_sel/w_we:
  - r_dout, r_led, r_seg, CNT, CMP, FLAG, r_irq.
  - Synchronizers, debounce counters and debounced levels.
  - Reset mid-debounce discards the partial count.
- r_led and r_seg are the register outputs directly; there is no extra delay after the write edge.

Test Plan:
- Write LED=0x0001ABCD, then read offset 0 -> r_dout=0x0000ABCD one cycle after the read; r_led=0xABCD after the write edge.
- Write SEG=0x05FFA000, then read offset 1 in the following cycle -> 0x05FFA000; a same-cycle write+read of SEG=0x1 -> r_dout shows 0x05FFA000, and the next read shows 0x1.
- Write CMP=20, write CNT=10 -> FLAG[0]=1 at the edge after the counter value 20; r_irq=1 one cycle later; write FLAG=0x1 -> FLAG=0, r_irq=0 next cycle.
- Write CNT=0xFFFFFFFE -> two cycles later the counter reads around 0x00000000 (wrap); with CMP=0 the wrap sets FLAG[0].
- Glitchy btnu pulses shorter than DEBOUNCE (DEBOUNCE=4: 3-cycle high, then low) -> BTN stays 0 and FLAG[1]=0; a stable 10-cycle high -> BTN bit0=1 at cycle 2+4 and FLAG[1]=1; W1C 0x2 on the same cycle as a fresh btnu edge -> FLAG[1] stays 1.
- Assert w_rst for one cycle mid-count and mid-debounce -> all outputs 0 next cycle; CNT restarts from 0; a read of BTN returns 0.

Source files
------------

// File: rtl/m_mmio_resp.sv
// MMIO responder on the data-memory port: LED/SEG registers, free-running counter with compare
// flag, debounced buttons with press flags. Read data is registered, one cycle of latency.
module m_mmio_resp #(
  parameter int DEBOUNCE = 16,
  parameter int LED_W    = 16
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_sel,
  input  logic [3:0]        w_addr,
  input  logic              w_we,
  input  logic [31:0]       w_din,
  output logic [31:0]       r_dout,
  input  logic              w_btnu,
  input  logic              w_btnd,
  output logic [LED_W-1:0]  r_led,
  output logic [31:0]       r_seg,
  output logic              r_irq
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [31:0]          dout_q, dout_d;
  logic [LED_W-1:0]     led_q, led_d;
  logic [31:0]          seg_q, seg_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [31:0]          cmp_q, cmp_d;
  logic [2:0]           flag_q, flag_d;
  logic                 irq_q;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           db_lvl_q, db_lvl_d;
  logic [1:0][DW-1:0]   db_cnt_q, db_cnt_d;
  logic [1:0]           rise;
  logic [2:0]           clr;
  logic                 wr;
  logic [31:0]          rd_val;

  always_comb begin
    wr    = w_sel & w_we;
    led_d = led_q;
    seg_d = seg_q;
    cmp_d = cmp_q;
    cnt_d = cnt_q + 32'd1;
    clr   = 3'b000;
    if (wr) begin
      case (w_addr)
        4'd0:    led_d = w_din[LED_W-1:0];
        4'd1:    seg_d = w_din;
        4'd2:    cnt_d = w_din;
        4'd3:    cmp_d = w_din;
        4'd5:    clr   = w_din[2:0];
        default: ;
      endcase
    end

    // Level flips only after DEBOUNCE consecutive differing samples; any agreement restarts the count.
    db_lvl_d = db_lvl_q;
    db_cnt_d = '0;
    rise     = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_lvl_q[i]) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE - 1)) begin
          db_lvl_d[i] = sync2_q[i];
          rise[i]     = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end

    // Set wins over a same-cycle write-1-to-clear.
    flag_d = (flag_q & ~clr) | {rise[1], rise[0], (cnt_q == cmp_q)};

    case (w_addr)
      4'd0:    rd_val = 32'(led_q);
      4'd1:    rd_val = seg_q;
      4'd2:    rd_val = cnt_q;
      4'd3:    rd_val = cmp_q;
      4'd4:    rd_val = {30'd0, db_lvl_q};
      4'd5:    rd_val = {29'd0, flag_q};
      default: rd_val = 32'd0;
    endcase
    dout_d = w_sel ? rd_val : dout_q;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      dout_q   <= '0;
      led_q    <= '0;
      seg_q    <= '0;
      cnt_q    <= '0;
      cmp_q    <= '0;
      flag_q   <= '0;
      irq_q    <= 1'b0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_lvl_q <= '0;
      db_cnt_q <= '0;
    end else begin
      dout_q   <= dout_d;
      led_q    <= led_d;
      seg_q    <= seg_d;
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
      flag_q   <= flag_d;
      irq_q    <= |flag_q;
      sync1_q  <= {w_btnd, w_btnu};
      sync2_q  <= sync1_q;
      db_lvl_q <= db_lvl_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign r_dout = dout_q;
  assign r_led  = led_q;
  assign r_seg  = seg_q;
  assign r_irq  = irq_q;

endmodule

// File: tb/tb_m_mmio_resp.sv
// Scoreboard bench for m_mmio_resp (DEBOUNCE=4): bus cycles push expected read data,
// a monitor pops and compares r_dout half a cycle after each selected edge.
module tb_m_mmio_resp;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_sel = 1'b0;
  logic [3:0]  w_addr = '0;
  logic        w_we = 1'b0;
  logic [31:0] w_din = '0;
  logic [31:0] r_dout;
  logic        w_btnu = 1'b0;
  logic        w_btnd = 1'b0;
  logic [15:0] r_led;
  logic [31:0] r_seg;
  logic        r_irq;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          chk;
    logic [31:0] v;
    string       name;
  } exp_t;
  exp_t sb[$];
  logic rv_q = 1'b0;

  m_mmio_resp #(.DEBOUNCE(4), .LED_W(16)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_sel(w_sel), .w_addr(w_addr), .w_we(w_we),
    .w_din(w_din), .r_dout(r_dout), .w_btnu(w_btnu), .w_btnd(w_btnd),
    .r_led(r_led), .r_seg(r_seg), .r_irq(r_irq)
  );

  always #5 w_clk = ~w_clk;

  always @(posedge w_clk) rv_q <= w_sel;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge w_clk);
      if (rv_q) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_underflow: r_dout=%h with no expected entry", r_dout);
        end else begin
          e = sb.pop_front();
          if (e.chk) begin
            checks++;
            if (r_dout !== e.v) begin
              failures++;
              $display("FAIL %s: got %h expected %h", e.name, r_dout, e.v);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One bus cycle; returns at #1 after the consuming edge.
  task automatic bus(input bit we, input logic [3:0] a, input logic [31:0] d,
                     input bit c, input logic [31:0] exp, input string name);
    exp_t e;
    w_sel = 1'b1; w_we = we; w_addr = a; w_din = d;
    e.chk = c; e.v = exp; e.name = name;
    sb.push_back(e);
    @(posedge w_clk); #1;
    w_sel = 1'b0; w_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge w_clk); #1; end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin : stim
    repeat (2) @(posedge w_clk);
    #1; w_rst = 1'b0;
    chk("rst_dout", r_dout, 32'h0);
    chk("rst_led", {16'h0, r_led}, 32'h0);
    chk("rst_seg", r_seg, 32'h0);
    chk("rst_irq", {31'h0, r_irq}, 32'h0);

    // LED: upper bits dropped, visible right after the write edge
    bus(1, 4'd0, 32'h0001ABCD, 0, 0, "");
    chk("led_out", {16'h0, r_led}, 32'h0000ABCD);
    bus(0, 4'd0, 0, 1, 32'h0000ABCD, "led_rd");

    // SEG: same-cycle write+read returns old value
    bus(1, 4'd1, 32'h05FFA000, 0, 0, "");
    bus(0, 4'd1, 0, 1, 32'h05FFA000, "seg_rd");
    bus(1, 4'd1, 32'h1, 1, 32'h05FFA000, "seg_wr_rd_old");
    bus(0, 4'd1, 0, 1, 32'h1, "seg_rd_new");
    chk("seg_out", r_seg, 32'h1);
    bus(0, 4'd9, 0, 1, 32'h0, "unmapped_rd");

    // CNT==CMP==0 on the first cycle after reset set FLAG[0]
    bus(0, 4'd5, 0, 1, 32'h1, "flag_after_rst");
    bus(1, 4'd5, 32'h7, 0, 0, "");
    bus(0, 4'd5, 0, 1, 32'h0, "flag_cleared");

    // Compare: CMP=20, CNT=10 -> match after 10 more edges
    bus(1, 4'd3, 32'd20, 0, 0, "");
    bus(1, 4'd2, 32'd10, 0, 0, "");
    idle(10);
    bus(0, 4'd5, 0, 1, 32'h0, "flag_pre_match");
    chk("irq_lag", {31'h0, r_irq}, 32'h0);
    bus(0, 4'd5, 0, 1, 32'h1, "flag_match");
    chk("irq_set", {31'h0, r_irq}, 32'h1);
    bus(1, 4'd5, 32'h1, 0, 0, "");
    bus(0, 4'd5, 0, 1, 32'h0, "flag_w1c");
    chk("irq_clr", {31'h0, r_irq}, 32'h0);

    // Wrap: CMP=0, CNT=FFFFFFFE
    bus(1, 4'd3, 32'd0, 0, 0, "");
    bus(1, 4'd2, 32'hFFFFFFFE, 0, 0, "");
    bus(0, 4'd2, 0, 1, 32'hFFFFFFFE, "cnt_written");
    bus(0, 4'd2, 0, 1, 32'hFFFFFFFF, "cnt_max");
    bus(0, 4'd5, 0, 1, 32'h0, "flag_wrap_pre");
    bus(0, 4'd5, 0, 1, 32'h1, "flag_wrap");
    bus(0, 4'd2, 0, 1, 32'h2, "cnt_after_wrap");
    bus(1, 4'd3, 32'hFFFF0000, 0, 0, "");
    bus(1, 4'd5, 32'h7, 0, 0, "");
    bus(0, 4'd3, 0, 1, 32'hFFFF0000, "cmp_rd");

    // Glitch: 3 cycles high never reaches DEBOUNCE
    w_btnu = 1'b1; idle(3);
    w_btnu = 1'b0; idle(6);
    bus(0, 4'd4, 0, 1, 32'h0, "btn_glitch");
    bus(0, 4'd5, 0, 1, 32'h0, "flag_glitch");

    // Stable press: level flips on the 6th edge after the input rises
    w_btnu = 1'b1; idle(5);
    bus(0, 4'd4, 0, 1, 32'h0, "btn_edge5");
    bus(0, 4'd4, 0, 1, 32'h1, "btn_edge6");
    chk("irq_btn", {31'h0, r_irq}, 32'h1);
    bus(0, 4'd5, 0, 1, 32'h2, "flag_btnu");
    idle(4);

    // Release, clear, then W1C on the same edge as a fresh press
    w_btnu = 1'b0; idle(8);
    bus(0, 4'd4, 0, 1, 32'h0, "btn_release");
    bus(1, 4'd5, 32'h2, 0, 0, "");
    bus(0, 4'd5, 0, 1, 32'h0, "flag_btnu_clr");
    w_btnu = 1'b1; idle(5);
    bus(1, 4'd5, 32'h2, 0, 0, "");
    bus(0, 4'd5, 0, 1, 32'h2, "flag_set_beats_clr");

    // btnd
    w_btnd = 1'b1; idle(7);
    bus(0, 4'd4, 0, 1, 32'h3, "btn_both");
    bus(0, 4'd5, 0, 1, 32'h6, "flag_both");

    // Reset mid-count and mid-debounce, with a write on the same edge
    w_btnu = 1'b0; idle(4);
    w_rst = 1'b1;
    bus(1, 4'd0, 32'hFFFF, 1, 32'h0, "rst_dout_mid");
    w_rst = 1'b0;
    chk("rst_led_mid", {16'h0, r_led}, 32'h0);
    chk("rst_seg_mid", r_seg, 32'h0);
    chk("rst_irq_mid", {31'h0, r_irq}, 32'h0);
    bus(0, 4'd4, 0, 1, 32'h0, "btn_after_rst");
    bus(0, 4'd2, 0, 1, 32'h1, "cnt_after_rst");

    idle(2);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
